// File: rtl/serial_compare_sequencer_if.sv
// Handshake and operand/result bundle for serial_compare_sequencer.
// The master drives start and operands; the slave (the sequencer) returns status and flags.
interface serial_compare_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic             A_greater_than_B;
    logic             A_equal_B;
    logic             A_less_than_B;

    modport master (
        output start, A, B,
        input  ready, done, A_greater_than_B, A_equal_B, A_less_than_B
    );

    modport slave (
        input  start, A, B,
        output ready, done, A_greater_than_B, A_equal_B, A_less_than_B
    );
endinterface

// File: rtl/serial_compare_sequencer.sv
// Digit-serial magnitude comparator: walks DIGIT-bit slices of A and B from the MSB,
// one slice per clock, and reports A>B / A==B / A<B with a start/ready/done handshake.
module serial_compare_sequencer #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 2,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    serial_compare_sequencer_if.slave    bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           state_r,   state_nxt_s;
    logic [WIDTH-1:0] a_sh_r,    a_sh_nxt_s;
    logic [WIDTH-1:0] b_sh_r,    b_sh_nxt_s;
    logic [CW-1:0]    cnt_r,     cnt_nxt_s;
    logic             gt_r,      gt_nxt_s;
    logic             eq_r,      eq_nxt_s;
    logic             lt_r,      lt_nxt_s;
    logic             decided_r, decided_nxt_s;
    logic             done_r,    done_nxt_s;
    logic [1:0]       cmp_s;

    // {greater, less} for one digit slice; 2'b00 means the digits match.
    function automatic logic [1:0] digit_cmp(input logic [DIGIT-1:0] a_dig,
                                             input logic [DIGIT-1:0] b_dig);
        return {(a_dig > b_dig), (a_dig < b_dig)};
    endfunction

    assign cmp_s = digit_cmp(a_sh_r[WIDTH-1 -: DIGIT], b_sh_r[WIDTH-1 -: DIGIT]);

    // Next-state and datapath update for the IDLE/COMPARE/DONE sequence.
    always_comb begin
        state_nxt_s   = state_r;
        a_sh_nxt_s    = a_sh_r;
        b_sh_nxt_s    = b_sh_r;
        cnt_nxt_s     = cnt_r;
        gt_nxt_s      = gt_r;
        eq_nxt_s      = eq_r;
        lt_nxt_s      = lt_r;
        decided_nxt_s = decided_r;
        done_nxt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    a_sh_nxt_s    = bus.A;
                    b_sh_nxt_s    = bus.B;
                    cnt_nxt_s     = CNT_LAST;
                    gt_nxt_s      = 1'b0;
                    eq_nxt_s      = 1'b0;
                    lt_nxt_s      = 1'b0;
                    decided_nxt_s = 1'b0;
                    state_nxt_s   = ST_COMPARE;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                if (EARLY_EXIT) begin
                    if (cmp_s != 2'b00) begin
                        gt_nxt_s    = cmp_s[1];
                        lt_nxt_s    = cmp_s[0];
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end else if (cnt_r == '0) begin
                        eq_nxt_s    = 1'b1;
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        a_sh_nxt_s  = a_sh_r << DIGIT;
                        b_sh_nxt_s  = b_sh_r << DIGIT;
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                    end
                end else begin
                    // Full scan: only the first differing digit decides, later ones are ignored.
                    if (!decided_r && (cmp_s != 2'b00)) begin
                        decided_nxt_s = 1'b1;
                        gt_nxt_s      = cmp_s[1];
                        lt_nxt_s      = cmp_s[0];
                    end else begin
                        decided_nxt_s = decided_r;
                    end
                    if (cnt_r == '0) begin
                        if (!decided_r && (cmp_s == 2'b00)) begin
                            eq_nxt_s = 1'b1;
                        end else begin
                            eq_nxt_s = eq_r;
                        end
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        a_sh_nxt_s  = a_sh_r << DIGIT;
                        b_sh_nxt_s  = b_sh_r << DIGIT;
                        cnt_nxt_s   = cnt_r - CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, operand shift registers, digit counter and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            a_sh_r    <= '0;
            b_sh_r    <= '0;
            cnt_r     <= '0;
            gt_r      <= 1'b0;
            eq_r      <= 1'b0;
            lt_r      <= 1'b0;
            decided_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            a_sh_r    <= a_sh_nxt_s;
            b_sh_r    <= b_sh_nxt_s;
            cnt_r     <= cnt_nxt_s;
            gt_r      <= gt_nxt_s;
            eq_r      <= eq_nxt_s;
            lt_r      <= lt_nxt_s;
            decided_r <= decided_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

    assign bus.ready            = (state_r == ST_IDLE);
    assign bus.done             = done_r;
    assign bus.A_greater_than_B = gt_r;
    assign bus.A_equal_B        = eq_r;
    assign bus.A_less_than_B    = lt_r;
endmodule

// File: tb/tb_serial_compare_sequencer.sv
// Randomized self-checking bench: an early-exit and a full-scan instance are driven in
// lock-step and compared against an arithmetic model of flags and latency.
module tb_serial_compare_sequencer;
    localparam int WIDTH = 8;
    localparam int DIGIT = 2;
    localparam int NDIG  = WIDTH / DIGIT;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    serial_compare_sequencer_if #(.WIDTH(WIDTH)) ifc_ee ();
    serial_compare_sequencer_if #(.WIDTH(WIDTH)) ifc_fs ();

    serial_compare_sequencer #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1'b1)) dut_ee (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc_ee.slave)
    );

    serial_compare_sequencer #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1'b0)) dut_fs (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc_fs.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        ifc_ee.start = st; ifc_ee.A = a; ifc_ee.B = b;
        ifc_fs.start = st; ifc_fs.A = a; ifc_fs.B = b;
    endtask

    function automatic int flags_ee();
        return int'({ifc_ee.A_greater_than_B, ifc_ee.A_equal_B, ifc_ee.A_less_than_B});
    endfunction

    function automatic int flags_fs();
        return int'({ifc_fs.A_greater_than_B, ifc_fs.A_equal_B, ifc_fs.A_less_than_B});
    endfunction

    function automatic int model_flags(input int a, input int b);
        if (a > b) return 4;
        else if (a == b) return 2;
        else return 1;
    endfunction

    // 1-based position (from MSB) of the first differing digit, or NDIG if none differ.
    function automatic int model_k(input int a, input int b);
        int mask;
        mask = (1 << DIGIT) - 1;
        for (int i = 0; i < NDIG; i++) begin
            int sh;
            sh = WIDTH - DIGIT * (i + 1);
            if (((a >> sh) & mask) != ((b >> sh) & mask)) return i + 1;
        end
        return NDIG;
    endfunction

    // One transaction on both instances; A/B are zeroed right after accept.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int exp_f, k_ee, n_done_ee, n_done_fs, lat_ee, lat_fs, rdy_ee, rdy_fs;
        exp_f = model_flags(int'(a), int'(b));
        k_ee  = model_k(int'(a), int'(b));
        n_done_ee = 0; n_done_fs = 0; lat_ee = 0; lat_fs = 0; rdy_ee = 0; rdy_fs = 0;
        @(negedge clk);
        check("ready_before_ee", int'(ifc_ee.ready), 1);
        check("ready_before_fs", int'(ifc_fs.ready), 1);
        drive(1'b1, a, b);
        @(posedge clk); #1;
        drive(1'b0, '0, '0);
        check("accept_clear_ee", flags_ee(), 0);
        check("accept_clear_fs", flags_fs(), 0);
        check("accept_busy_ee", int'(ifc_ee.ready), 0);
        for (int c = 1; c <= NDIG + 2; c++) begin
            @(posedge clk); #1;
            if (ifc_ee.done) begin
                n_done_ee++; lat_ee = c;
                check("flags_ee", flags_ee(), exp_f);
                check("ready_in_done_ee", int'(ifc_ee.ready), 0);
            end
            if (ifc_fs.done) begin
                n_done_fs++; lat_fs = c;
                check("flags_fs", flags_fs(), exp_f);
            end
            if (ifc_ee.ready && rdy_ee == 0) rdy_ee = c;
            if (ifc_fs.ready && rdy_fs == 0) rdy_fs = c;
        end
        check("done_count_ee", n_done_ee, 1);
        check("done_count_fs", n_done_fs, 1);
        check("latency_ee", lat_ee, k_ee);
        check("latency_fs", lat_fs, NDIG);
        check("ready_ret_ee", rdy_ee, k_ee + 1);
        check("ready_ret_fs", rdy_fs, NDIG + 1);
        check("held_ee", flags_ee(), exp_f);
        check("held_fs", flags_fs(), exp_f);
    endtask

    initial begin
        int n_done_ee, n_done_fs, mode;
        logic [WIDTH-1:0] ra, rb;
        n_checks = 0;
        n_errors = 0;
        drive(1'b0, '0, '0);
        rst_n = 1'b0;
        #23;
        check("rst_ready_ee", int'(ifc_ee.ready), 1);
        check("rst_ready_fs", int'(ifc_fs.ready), 1);
        check("rst_done_ee", int'(ifc_ee.done), 0);
        check("rst_flags_ee", flags_ee(), 0);
        check("rst_flags_fs", flags_fs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'hC3, 8'h43);
        run_op(8'h5A, 8'h5B);
        run_op(8'hA5, 8'hA5);
        run_op(8'hFF, 8'h00);
        run_op(8'h00, 8'hFF);
        run_op(8'h00, 8'h00);

        // Abort a compare with reset: outputs return to idle at once, no done follows.
        @(negedge clk);
        drive(1'b1, 8'h5A, 8'h5B);
        @(posedge clk); #1;
        drive(1'b0, '0, '0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready_ee", int'(ifc_ee.ready), 1);
        check("abort_ready_fs", int'(ifc_fs.ready), 1);
        check("abort_done_ee", int'(ifc_ee.done), 0);
        check("abort_flags_ee", flags_ee(), 0);
        check("abort_flags_fs", flags_fs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n_done_ee = 0;
        for (int c = 0; c < NDIG + 2; c++) begin
            @(posedge clk); #1;
            if (ifc_ee.done || ifc_fs.done) n_done_ee++;
        end
        check("abort_no_done", n_done_ee, 0);
        run_op(8'h5A, 8'h5B);

        // start held high from reset release: each op takes k+2 cycles back-to-back.
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 8'hC3, 8'h43);
        @(negedge clk);
        rst_n = 1'b1;
        n_done_ee = 0; n_done_fs = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (ifc_ee.done) begin
                n_done_ee++;
                check("b2b_flags_ee", flags_ee(), 4);
            end
            if (ifc_fs.done) begin
                n_done_fs++;
                check("b2b_flags_fs", flags_fs(), 4);
            end
        end
        check("b2b_count_ee", n_done_ee, 10);
        check("b2b_count_fs", n_done_fs, 5);
        @(negedge clk);
        drive(1'b0, '0, '0);
        for (int c = 0; c < NDIG + 2; c++) @(posedge clk);

        for (int i = 0; i < 1000; i++) begin
            mode = int'($urandom_range(0, 3));
            ra = WIDTH'($urandom_range(0, 255));
            if (mode == 1) rb = ra;
            else if (mode == 2) rb = ra ^ WIDTH'($urandom_range(1, 3));
            else rb = WIDTH'($urandom_range(0, 255));
            run_op(ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
